// File: rtl/sap_bus_pkg.sv
// Shared 8-line bus fabric types and sizes.
// Used by the mux/demux ends of the fabric.
package sap_bus_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int BUS_LINES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] line_sel_t;
endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority encoder: first set req bit
// at or after ptr, wrapping modulo 8.
module rr_pick_8
  import sap_bus_pkg::*;
(
  input  logic [7:0] req,
  input  line_sel_t  ptr,
  output line_sel_t  gnt_idx,
  output logic       gnt_any
);

  line_sel_t idx;

  // Walk offsets high to low so the nearest one wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + line_sel_t'(k);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_8line_8bit.sv
// Round-robin 8:1 collecting mux with registered output.
// Optional burst lock on a line: define MUX_LOCK_EN.
module mux_arb_8line_8bit
  import sap_bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int LINES = BUS_LINES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [LINES-1:0] in_valid,
  output logic [LINES-1:0] in_ready,
`ifdef MUX_LOCK_EN
  input  logic [LINES-1:0] in_lock,
`endif
  output logic [WIDTH-1:0] out_data,
  output line_sel_t        out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] in_arr [8];
  logic [WIDTH-1:0] data_q, data_d;
  line_sel_t        sel_q, sel_d;
  logic             valid_q, valid_d;
  line_sel_t        rr_ptr_q, rr_ptr_d;
  line_sel_t        pick_idx, gnt_idx;
  logic             pick_any, gnt_any;
  logic             load, xfer;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;
  assign in_arr[7] = in7;

  rr_pick_8 u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

`ifdef MUX_LOCK_EN
  logic      lock_q, lock_d;
  line_sel_t lidx_q, lidx_d;

  // A held grant ignores every other requester.
  always_comb begin
    gnt_idx = lock_q ? lidx_q : pick_idx;
    gnt_any = lock_q ? in_valid[lidx_q] : pick_any;
  end
`else
  assign gnt_idx = pick_idx;
  assign gnt_any = pick_any;
`endif

  assign load = !valid_q || out_ready;
  assign xfer = load && gnt_any && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MUX_LOCK_EN
    lock_d   = lock_q;
    lidx_d   = lidx_q;
`endif
    if (load) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        data_d   = in_arr[gnt_idx];
        sel_d    = gnt_idx;
        rr_ptr_d = gnt_idx + 3'd1;
`ifdef MUX_LOCK_EN
        lock_d = in_lock[gnt_idx];
        lidx_d = gnt_idx;
        if (in_lock[gnt_idx]) rr_ptr_d = rr_ptr_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
`ifdef MUX_LOCK_EN
      lock_q   <= 1'b0;
      lidx_q   <= '0;
`endif
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MUX_LOCK_EN
      lock_q   <= lock_d;
      lidx_q   <= lidx_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_8line_8bit.sv
// Bench for mux_arb_8line_8bit: directed scenarios plus
// random traffic against a queue-free arbitration model.
module tb_mux_arb_8line_8bit;

  logic       clk = 0;
  logic       rst;
  logic [7:0] din [8];
  logic [7:0] in_valid;
  logic [7:0] in_ready;
  logic [7:0] in_lock;
  logic [7:0] out_data;
  logic [2:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int       m_ptr;
  logic     m_valid;
  int       m_sel;
  logic [7:0] m_data;
  logic     m_lock;
  int       m_lidx;
  logic [7:0] exp_rdy, got_rdy;

  always #5 clk = ~clk;

  mux_arb_8line_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .in4       (din[4]),
    .in5       (din[5]),
    .in6       (din[6]),
    .in7       (din[7]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int exp_grant(logic [7:0] v, int ptr);
    for (int k = 0; k < 8; k++)
      if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sel = 0; m_data = 0;
    m_lock = 0; m_lidx = 0;
  endtask

  // One clock: sample in_ready, advance DUT and model, settle.
  task automatic cyc();
    int g;
    logic ld;
    logic [7:0] d;
    #1;
    g = exp_grant(in_valid, m_ptr);
`ifdef MUX_LOCK_EN
    if (m_lock) g = in_valid[m_lidx] ? m_lidx : -1;
`endif
    ld = !m_valid || out_ready;
    exp_rdy = (ld && g >= 0) ? (8'd1 << g) : 8'd0;
    got_rdy = in_ready;
    d = (g >= 0) ? din[g] : 8'h00;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = d; m_sel = g;
`ifdef MUX_LOCK_EN
        if (in_lock[g]) begin
          m_lock = 1; m_lidx = g;
        end else begin
          m_lock = 0; m_ptr = (g + 1) % 8;
        end
`else
        m_ptr = (g + 1) % 8;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 8'hFF; out_ready = 1; in_lock = 0;
    for (int i = 0; i < 8; i++) din[i] = 8'hC0 + 8'(i);
    model_reset();
    #7;
    n_chk++;
    if (out_valid !== 0 || out_data !== 0 || out_sel !== 0 || in_ready !== 0) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h s=%0d rdy=%h want 0/00/0/00",
               out_valid, out_data, out_sel, in_ready);
    end
    @(posedge clk); #2;
    rst = 0;
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    din[3] = 8'h5A; in_valid = 8'h08; out_ready = 1;
    cyc();
    n_chk++;
    if (got_rdy !== 8'h08) begin
      n_fail++;
      $display("FAIL single_rdy: got %h want 08", got_rdy);
    end
    n_chk++;
    if (out_data !== 8'h5A || out_sel !== 3 || out_valid !== 1) begin
      n_fail++;
      $display("FAIL single_out: got %h/%0d/%b want 5a/3/1",
               out_data, out_sel, out_valid);
    end
    in_valid = 0;
    cyc();
    n_chk++;
    if (out_valid !== 0 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%b d=%h want 0/5a", out_valid, out_data);
    end
  endtask

  task automatic test_round_robin();
    // pointer is at 4 after test_single; realign by a reset
    rst = 1; #2; rst = 0; model_reset();
    for (int i = 0; i < 8; i++) din[i] = 8'h10 + 8'(i);
    in_valid = 8'hFF; out_ready = 1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      n_chk++;
      if (out_sel !== 3'(n % 8) || out_data !== 8'h10 + 8'(n % 8) ||
          out_valid !== 1 || got_rdy !== 8'd1 << (n % 8)) begin
        n_fail++;
        $display("FAIL rr[%0d]: got s=%0d d=%h v=%b rdy=%h want s=%0d d=%h",
                 n, out_sel, out_data, out_valid, got_rdy, n % 8, 8'h10 + n % 8);
      end
    end
  endtask

  task automatic test_wrap_skip();
    in_valid = 8'h40; cyc();
    in_valid = 8'h06;
    for (int n = 0; n < 4; n++) begin
      cyc();
      n_chk++;
      if (out_sel !== 3'((n % 2) + 1) || got_rdy[0] !== 0) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got s=%0d rdy=%h want s=%0d",
                 n, out_sel, got_rdy, (n % 2) + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    in_valid = 8'hFF; out_ready = 1; cyc();
    held = out_data;
    out_ready = 0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      n_chk++;
      if (got_rdy !== 0 || out_data !== held || out_valid !== 1) begin
        n_fail++;
        $display("FAIL stall[%0d]: got rdy=%h d=%h v=%b want 00/%h/1",
                 n, got_rdy, out_data, out_valid, held);
      end
    end
    out_ready = 1;
    cyc();
    n_chk++;
    if (got_rdy !== exp_rdy || got_rdy === 0 || out_sel !== 3'(m_sel) ||
        out_data !== m_data) begin
      n_fail++;
      $display("FAIL resume: got rdy=%h s=%0d d=%h want rdy=%h s=%0d d=%h",
               got_rdy, out_sel, out_data, exp_rdy, m_sel, m_data);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 8'hFF; out_ready = 1;
    cyc(); cyc(); cyc();
    #2; rst = 1; #1;
    model_reset();
    n_chk++;
    if (out_valid !== 0 || out_data !== 0 || out_sel !== 0 || in_ready !== 0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b d=%h s=%0d rdy=%h want 0/00/0/00",
               out_valid, out_data, out_sel, in_ready);
    end
    #1; rst = 0;
    cyc();
    n_chk++;
    if (got_rdy !== 8'h01 || out_sel !== 0 || out_data !== din[0]) begin
      n_fail++;
      $display("FAIL rst_first: got rdy=%h s=%0d want 01/0", got_rdy, out_sel);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
      in_valid = 8'($urandom);
      if ($urandom_range(3) == 0) in_valid = 0;
      out_ready = ($urandom_range(3) != 0);
      cyc();
      n_chk++;
      if (got_rdy !== exp_rdy || out_valid !== m_valid ||
          (m_valid && (out_sel !== 3'(m_sel) || out_data !== m_data))) begin
        n_fail++;
        $display("FAIL rand[%0d]: got rdy=%h v=%b s=%0d d=%h want %h/%b/%0d/%h",
                 n, got_rdy, out_valid, out_sel, out_data,
                 exp_rdy, m_valid, m_sel, m_data);
      end
    end
  endtask

`ifdef MUX_LOCK_EN
  task automatic test_lock();
    rst = 1; #2; rst = 0; model_reset();
    out_ready = 1; in_lock = 0;
    in_valid = 8'h02; cyc();
    in_valid = 8'h06; in_lock = 8'h04;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) in_lock = 0;
      cyc();
      n_chk++;
      if (out_sel !== 2 || got_rdy !== 8'h04) begin
        n_fail++;
        $display("FAIL lock[%0d]: got s=%0d rdy=%h want 2/04", n, out_sel, got_rdy);
      end
    end
    cyc();
    n_chk++;
    if (out_sel !== 1 || got_rdy !== 8'h02) begin
      n_fail++;
      $display("FAIL unlock: got s=%0d rdy=%h want 1/02", out_sel, got_rdy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MUX_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
